// File: rtl/mem_req_scheduler.sv
// Miss/write-back scheduler: forwards hits from the write-back buffer, otherwise
// arbitrates line reads against buffer drains on a single memory request channel.
module mem_req_scheduler #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 128,
    parameter int unsigned MAX_RD_STREAK = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  miss_valid_i,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    output logic                  refill_valid_o,
    output logic [DATA_WIDTH-1:0] refill_data_o,
    input  logic                  wb_valid_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  wb_ready_o,
    input  logic                  wb_not_full_i,
    output logic [ADDR_WIDTH-1:0] wb_raddr_o,
    input  logic                  wb_hit_i,
    input  logic [DATA_WIDTH-1:0] wb_rdata_i,
    output logic                  wb_clr_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_RD_REQ,
        S_RD_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_RD_STREAK);

    state_t                r_state;
    logic [3:0]            r_streak;
    logic                  r_rd_wb;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_refill_valid;
    logic [DATA_WIDTH-1:0] r_refill_data;

    logic w_fwd;
    logic w_wr;

    assign w_fwd = miss_valid_i & wb_hit_i;
    assign w_wr  = wb_valid_i & (~wb_not_full_i | ~miss_valid_i | (r_streak == STREAK_MAX));

    // Clear and pop must coincide with the forwarding/grant cycle, so they are
    // decoded from state; rstn_i gating keeps the clear low while in reset.
    assign wb_raddr_o = miss_addr_i;
    assign wb_clr_o   = rstn_i & (r_state == S_IDLE) & w_fwd;
    assign wb_ready_o = (r_state == S_WR_REQ) & mem_gnt_i;

    assign mem_req_o      = r_mem_req;
    assign mem_we_o       = r_mem_we;
    assign mem_addr_o     = r_mem_addr;
    assign mem_wdata_o    = r_mem_wdata;
    assign refill_valid_o = r_refill_valid;
    assign refill_data_o  = r_refill_data;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state        <= S_IDLE;
            r_streak       <= '0;
            r_rd_wb        <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_refill_valid <= 1'b0;
            r_refill_data  <= '0;
        end else begin
            r_refill_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fwd) begin
                        r_refill_data  <= wb_rdata_i;
                        r_refill_valid <= 1'b1;
                        r_state        <= S_RESP;
                    end else if (w_wr) begin
                        r_mem_addr  <= wb_addr_i;
                        r_mem_wdata <= wb_data_i;
                        r_mem_we    <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_state     <= S_WR_REQ;
                    end else if (miss_valid_i) begin
                        r_mem_addr <= miss_addr_i;
                        r_mem_we   <= 1'b0;
                        r_mem_req  <= 1'b1;
                        r_rd_wb    <= wb_valid_i;
                        if (!wb_valid_i) begin
                            r_streak <= '0;
                        end
                        r_state <= S_RD_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (mem_gnt_i) begin
                        r_mem_req <= 1'b0;
                        r_streak  <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    if (mem_gnt_i) begin
                        r_mem_req <= 1'b0;
                        if (r_rd_wb && (r_streak != STREAK_MAX)) begin
                            r_streak <= r_streak + 4'd1;
                        end
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_refill_data  <= mem_rdata_i;
                        r_refill_valid <= 1'b1;
                        r_state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
